// File: rtl/im_loader_pkg.sv
// Shared types and sizes for the instruction-memory loader.
package im_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_W         = 16;
    localparam int WORD_W         = 32;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        LEN_HI  = 3'd0,
        LEN_LO  = 3'd1,
        BYTE    = 3'd2,
        WRITE   = 3'd3,
        DONE_ST = 3'd4
    } state_e;

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface im_loader_if;
    import im_loader_pkg::*;

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    // Loader side: consumes the stream, drives the memory write port.
    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );

    // Environment side: produces the stream, observes the writes.
    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/im_loader_word_asm.sv
// Big-endian word assembler: shifts bytes in MSB first and tracks the byte index.
module word_asm
    import im_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              shift_en_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_nxt_o,
    output logic              full_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // The word as it will look once byte_i has been shifted in.
    assign word_nxt_o = {word_q[WORD_W-9:0], byte_i};
    // The next accepted byte completes the word.
    assign full_o     = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

    // Next-state for the shift register and byte index; clear wins over shift.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clr_i) begin
            word_d = '0;
            idx_d  = '0;
        end else if (shift_en_i) begin
            word_d = word_nxt_o;
            idx_d  = idx_q + IDX_W'(1);
        end else begin
            word_d = word_q;
            idx_d  = idx_q;
        end
    end

    // Assembler state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: parses a length-prefixed big-endian byte stream,
// writes one word per WRITE cycle and releases the core when the load is done.
module im_loader
    import im_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    im_loader_if.slave        bus,
    output logic              cpu_rst_f_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] words_loaded_o
);

    state_e            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              in_ready_q, wr_en_q, done_q;
    logic              xfer_s, shift_en_s, clr_s, full_s;
    logic [WORD_W-1:0] word_nxt_s;

    // in_ready_q is registered from the next state, so it mirrors the accepting states.
    assign xfer_s = bus.in_valid & in_ready_q;

    word_asm u_word_asm (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (clr_s),
        .shift_en_i (shift_en_s),
        .byte_i     (bus.in_data),
        .word_nxt_o (word_nxt_s),
        .full_o     (full_s)
    );

    // Next-state logic: length header, byte collection, one-cycle write, terminal done.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        shift_en_s = 1'b0;
        clr_s      = 1'b0;
        case (state_q)
            LEN_HI: begin
                if (xfer_s) begin
                    n_d     = {bus.in_data, n_q[7:0]};
                    state_d = LEN_LO;
                end else begin
                    state_d = LEN_HI;
                end
            end
            LEN_LO: begin
                if (xfer_s) begin
                    n_d   = {n_q[15:8], bus.in_data};
                    clr_s = 1'b1;
                    if (n_d == 16'd0) begin
                        state_d = DONE_ST;
                    end else begin
                        state_d = BYTE;
                    end
                end else begin
                    state_d = LEN_LO;
                end
            end
            BYTE: begin
                if (xfer_s) begin
                    shift_en_s = 1'b1;
                    if (full_s) begin
                        // Capture address and word now so the strobe cycle presents them.
                        state_d   = WRITE;
                        wr_addr_d = cnt_q;
                        wr_data_d = word_nxt_s;
                    end else begin
                        state_d = BYTE;
                    end
                end else begin
                    state_d = BYTE;
                end
            end
            WRITE: begin
                cnt_d = cnt_q + 16'd1;
                if ((cnt_q + 16'd1) == n_q) begin
                    state_d = DONE_ST;
                end else begin
                    state_d = BYTE;
                end
            end
            DONE_ST: begin
                state_d = DONE_ST;
            end
            default: begin
                state_d = LEN_HI;
            end
        endcase
    end

    // State, header, counter and write-port registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= LEN_HI;
            n_q       <= 16'd0;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Status outputs registered from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            in_ready_q <= (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == BYTE);
            wr_en_q    <= (state_d == WRITE);
            done_q     <= (state_d == DONE_ST);
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign done_o          = done_q;
    assign cpu_rst_f_o     = done_q;
    assign words_loaded_o  = cnt_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: scoreboard of expected memory writes plus
// directed checks on handshake, completion and reset behaviour.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_rst_f;
    logic        done;
    logic [15:0] words_loaded;

    im_loader_if bus_if ();

    im_loader dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus_if),
        .cpu_rst_f_o    (cpu_rst_f),
        .done_o         (done),
        .words_loaded_o (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [47:0] sb_q[$];
    int          wr_seen  = 0;
    logic        active   = 1'b0;
    logic [31:0] wbuf[4];

    // Count one comparison and report it if it differs.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write;
    // while loading, in_ready is low exactly in write cycles.
    always @(negedge clk) begin
        if (bus_if.wr_en === 1'b1) begin
            wr_seen++;
            if (sb_q.size() == 0) begin
                chk("wr_unexpected", {16'd0, bus_if.wr_addr, bus_if.wr_data}, 64'd0);
            end else begin
                logic [47:0] e;
                e = sb_q.pop_front();
                chk("wr_addr", {48'd0, bus_if.wr_addr}, {48'd0, e[47:32]});
                chk("wr_data", {32'd0, bus_if.wr_data}, {32'd0, e[31:0]});
            end
        end
        if (active && !done) begin
            chk("rdy_vs_wr", {63'd0, bus_if.in_ready}, {63'd0, ~bus_if.wr_en});
        end
    end

    // Offer one byte after an optional random idle gap; returns on the negedge after the transfer.
    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int gap;
        int guard;
        gap   = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
        guard = 0;
        bus_if.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = b;
        while (bus_if.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
    endtask

    // Send a full load of n words from wbuf; returns in the cycle after the last transfer.
    task automatic send_load(input int n, input int gapmax);
        send_byte(8'(n >> 8), gapmax);
        send_byte(8'(n), gapmax);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (b == 3) sb_q.push_back({16'(i), wbuf[i]});
                send_byte(wbuf[i][8*(3-b) +: 8], gapmax);
            end
            chk("wr_latency", {63'd0, bus_if.wr_en}, 64'd1);
        end
    endtask

    // Synchronous reset with checks on the reset state and the first ready cycle.
    task automatic do_reset();
        active = 1'b0;
        rst    = 1'b1;
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_wr_en",    {63'd0, bus_if.wr_en},    64'd0);
        chk("rst_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
        chk("rst_cpu",      {63'd0, cpu_rst_f},       64'd0);
        chk("rst_done",     {63'd0, done},            64'd0);
        chk("rst_words",    {48'd0, words_loaded},    64'd0);
        chk("rst_addr",     {48'd0, bus_if.wr_addr},  64'd0);
        chk("rst_data",     {32'd0, bus_if.wr_data},  64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        @(negedge clk);
        chk("rdy_post_rst", {63'd0, bus_if.in_ready}, 64'd1);
        active = 1'b1;
    endtask

    // Check the terminal state after a completed load.
    task automatic chk_done(input int n, input int wr_expected, input int wr_before);
        chk("done",        {63'd0, done},         64'd1);
        chk("cpu_rst_f",   {63'd0, cpu_rst_f},    64'd1);
        chk("done_rdy",    {63'd0, bus_if.in_ready}, 64'd0);
        chk("words_final", {48'd0, words_loaded}, 64'(n));
        chk("wr_count",    64'(wr_seen - wr_before), 64'(wr_expected));
    endtask

    // Stop the run if something stalls far beyond any expected length.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 8'h00;
        @(negedge clk);
        do_reset();

        // One word DEADBEEF.
        w0 = wr_seen;
        wbuf[0] = 32'hDEADBEEF;
        send_load(1, 0);
        chk("cpu_low_in_wr", {63'd0, cpu_rst_f}, 64'd0);
        @(negedge clk);
        chk_done(1, 1, w0);
        chk("hold_addr", {48'd0, bus_if.wr_addr}, 64'h0000);
        chk("hold_data", {32'd0, bus_if.wr_data}, 64'hDEADBEEF);

        // Three words at consecutive addresses.
        do_reset();
        w0 = wr_seen;
        wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333;
        send_load(3, 0);
        chk("done_early", {63'd0, done}, 64'd0);
        @(negedge clk);
        chk_done(3, 3, w0);

        // Empty load: done one cycle after the length low byte.
        do_reset();
        w0 = wr_seen;
        send_load(0, 0);
        chk_done(0, 0, w0);

        // Two words without gaps, then the same words with random gaps.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            w0 = wr_seen;
            wbuf[0] = 32'hA5A50F0F; wbuf[1] = 32'h12345678;
            send_load(2, pass * 5);
            @(negedge clk);
            chk_done(2, 2, w0);
        end
        // Bytes offered after completion are ignored.
        w0 = wr_seen;
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_if.in_data = 8'($urandom);
            @(negedge clk);
            chk("post_done_rdy", {63'd0, bus_if.in_ready}, 64'd0);
        end
        bus_if.in_valid = 1'b0;
        chk("post_done_wr",    64'(wr_seen - w0), 64'd0);
        chk("post_done_words", {48'd0, words_loaded}, 64'd2);

        // Reset landing on the write cycle.
        do_reset();
        wbuf[0] = 32'h0BADF00D; wbuf[1] = 32'h55AA55AA;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int b = 0; b < 4; b++) begin
            if (b == 3) sb_q.push_back({16'd0, wbuf[0]});
            send_byte(wbuf[0][8*(3-b) +: 8], 0);
        end
        chk("wr_in_flight", {63'd0, bus_if.wr_en}, 64'd1);
        do_reset();

        // Reset after a partial word, then a fresh single-word load.
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h99, 0);
        send_byte(8'h77, 0);
        do_reset();
        w0 = wr_seen;
        wbuf[0] = 32'hCAFEF00D;
        send_load(1, 0);
        @(negedge clk);
        chk_done(1, 1, w0);
        chk("fresh_data", {32'd0, bus_if.wr_data}, 64'hCAFEF00D);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
